csr_bus_arbiter: RTL and testbench

- Shares the single CSR peripheral bus (id, counter, pins, UART and timer CSR units) between two requesters: requester 0 is the core pipeline, requester 1 is the debug/host agent.
- Grants one transaction at a time and drives the bus for exactly one cycle.
- Merges the registered responses of all peripherals and returns data plus a hit flag to the granted requester.
- Holds the bus at an inert idle address at all other times, so no unintended modify side effects occur.

---
 rtl/csr_arb_pkg.sv | 26 ++
 rtl/csr_arb_pick.sv | 31 +++
 rtl/csr_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_csr_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_arb_pkg.sv
// Shared types and constants for the CSR bus arbiter: FSM states, modify codes,
// default idle address and the latched transaction record.
package csr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } arb_state_e;

    localparam logic [2:0] MOD_NONE  = 3'b000;
    localparam logic [2:0] MOD_WRITE = 3'b001;
    localparam logic [2:0] MOD_SET   = 3'b010;
    localparam logic [2:0] MOD_CLEAR = 3'b011;

    // Must not decode to any peripheral on the bus.
    localparam logic [11:0] CSR_IDLE_ADDR = 12'h000;

    typedef struct packed {
        logic        read;
        logic [2:0]  modify;
        logic [31:0] wdata;
        logic [11:0] addr;
    } csr_txn_t;

endpackage

// File: rtl/csr_arb_pick.sv
// Two-requester grant selection returning a one-hot grant.
// CSR_ARB_ROUND_ROBIN_EN selects round-robin; otherwise requester 0 has fixed priority.
module csr_arb_pick (
    input  logic [1:0] elig_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

`ifdef CSR_ARB_ROUND_ROBIN_EN
    // On a tie the requester that was not granted last wins.
    always_comb begin
        if (elig_i == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = elig_i;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        if (elig_i[0]) begin
            grant_o = 2'b01;
        end else begin
            grant_o = {elig_i[1], 1'b0};
        end
    end
`endif

endmodule

// File: rtl/csr_bus_arbiter.sv
// Shares the CSR peripheral bus between the core (req 0) and the debug agent (req 1),
// one 3-cycle transaction at a time. CSR_ARB_ROUND_ROBIN_EN enables round-robin grants.
module csr_bus_arbiter
    import csr_arb_pkg::*;
#(
    parameter int          NPERIPH   = 6,
    parameter logic [11:0] IDLE_ADDR = CSR_IDLE_ADDR
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [1:0]             req,
    input  logic [1:0]             req_read,
    input  logic [5:0]             req_modify,
    input  logic [63:0]            req_wdata,
    input  logic [23:0]            req_addr,
    output logic [1:0]             ack,
    output logic [31:0]            rdata,
    output logic                   hit,
    output logic                   bus_read,
    output logic [2:0]             bus_modify,
    output logic [31:0]            bus_wdata,
    output logic [11:0]            bus_addr,
    input  logic [32*NPERIPH-1:0]  periph_rdata,
    input  logic [NPERIPH-1:0]     periph_valid
);

    arb_state_e  state_q, state_d;
    csr_txn_t    txn_q, txn_d, cand;
    logic        owner_q, owner_d;
    logic [1:0]  ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        hit_q, hit_d;

    logic [1:0]  elig;
    logic [1:0]  grant;
    logic        grant_fire;
    logic        last_grant;
    logic [31:0] resp_rdata;
    logic        resp_hit;

    // A requester is deaf during its own ack cycle: it is dropping req right then.
    assign elig       = req & ~ack_q;
    assign grant_fire = (state_q == IDLE) && (|elig);

    csr_arb_pick u_pick (
        .elig_i  (elig),
        .last_i  (last_grant),
        .grant_o (grant)
    );

`ifdef CSR_ARB_ROUND_ROBIN_EN
    logic last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else if (grant_fire) begin
            last_q <= grant[1];
        end
    end

    assign last_grant = last_q;
`else
    assign last_grant = 1'b1;
`endif

    assign cand = grant[1] ? {req_read[1], req_modify[5:3], req_wdata[63:32], req_addr[23:12]}
                           : {req_read[0], req_modify[2:0], req_wdata[31:0],  req_addr[11:0]};

    // Response merge: peripherals drive zero when not addressed, so OR is a safe mux.
    logic [31:0] slice [NPERIPH];

    for (genvar g = 0; g < NPERIPH; g++) begin : g_slice
        assign slice[g] = periph_rdata[32*g +: 32];
    end

    always_comb begin
        resp_rdata = '0;
        for (int i = 0; i < NPERIPH; i++) begin
            resp_rdata = resp_rdata | slice[i];
        end
    end

    assign resp_hit = |periph_valid;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default every comb output first; a missed branch would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (|elig) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs: driven only in ISSUE, so modify side effects occur exactly once.
    always_comb begin
        bus_read   = 1'b0;
        bus_modify = MOD_NONE;
        bus_wdata  = '0;
        bus_addr   = IDLE_ADDR;
        if (state_q == ISSUE) begin
            bus_read   = txn_q.read;
            bus_modify = txn_q.modify;
            bus_wdata  = txn_q.wdata;
            bus_addr   = txn_q.addr;
        end
    end

    // Transaction latch and response capture
    always_comb begin
        txn_d   = txn_q;
        owner_d = owner_q;
        ack_d   = 2'b00;
        rdata_d = rdata_q;
        hit_d   = hit_q;
        if (grant_fire) begin
            txn_d   = cand;
            owner_d = grant[1];
        end
        if (state_q == CAPTURE) begin
            ack_d   = owner_q ? 2'b10 : 2'b01;
            rdata_d = resp_rdata;
            hit_d   = resp_hit;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txn_q   <= '{read: 1'b0, modify: MOD_NONE, wdata: '0, addr: IDLE_ADDR};
            owner_q <= 1'b0;
            ack_q   <= 2'b00;
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            txn_q   <= txn_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign hit   = hit_q;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Directed self-checking bench for csr_bus_arbiter; a small registered peripheral
// model answers addresses F11 (p0), 300 (p1+p2) and BC1 (p3).
module tb_csr_bus_arbiter;
    import csr_arb_pkg::*;

    localparam int NP = 6;

    logic              clk;
    logic              rstn;
    logic [1:0]        req;
    logic [1:0]        req_read;
    logic [5:0]        req_modify;
    logic [63:0]       req_wdata;
    logic [23:0]       req_addr;
    logic [1:0]        ack;
    logic [31:0]       rdata;
    logic              hit;
    logic              bus_read;
    logic [2:0]        bus_modify;
    logic [31:0]       bus_wdata;
    logic [11:0]       bus_addr;
    logic [32*NP-1:0]  periph_rdata;
    logic [NP-1:0]     periph_valid;

    int n_checks = 0;
    int n_fail   = 0;

    csr_bus_arbiter #(
        .NPERIPH   (NP),
        .IDLE_ADDR (CSR_IDLE_ADDR)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req          (req),
        .req_read     (req_read),
        .req_modify   (req_modify),
        .req_wdata    (req_wdata),
        .req_addr     (req_addr),
        .ack          (ack),
        .rdata        (rdata),
        .hit          (hit),
        .bus_read     (bus_read),
        .bus_modify   (bus_modify),
        .bus_wdata    (bus_wdata),
        .bus_addr     (bus_addr),
        .periph_rdata (periph_rdata),
        .periph_valid (periph_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Registered peripherals: respond in the cycle after the address is on the bus.
    initial begin
        logic [11:0] a;
        periph_valid = '0;
        periph_rdata = '0;
        forever begin
            @(negedge clk);
            a = bus_addr;
            @(posedge clk);
            #1;
            periph_valid = '0;
            periph_rdata = '0;
            case (a)
                12'hF11: begin
                    periph_valid[0]      = 1'b1;
                    periph_rdata[31:0]   = 32'h0000_0005;
                end
                12'h300: begin
                    periph_valid[1]      = 1'b1;
                    periph_valid[2]      = 1'b1;
                    periph_rdata[63:32]  = 32'h0000_000F;
                    periph_rdata[95:64]  = 32'h0000_00F0;
                end
                12'hBC1: begin
                    periph_valid[3]      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    task automatic set_fields(input int idx, input logic rd, input logic [2:0] mod,
                              input logic [31:0] wd, input logic [11:0] addr);
        req_read[idx]             = rd;
        req_modify[3*idx +: 3]    = mod;
        req_wdata[32*idx +: 32]   = wd;
        req_addr[12*idx +: 12]    = addr;
    endtask

    // One isolated transaction, checking the bus and response cycle by cycle.
    task automatic do_txn(input int idx, input logic rd, input logic [2:0] mod,
                          input logic [31:0] wd, input logic [11:0] addr,
                          input logic [31:0] exp_rdata, input logic exp_hit, input string tag);
        logic [1:0] exp_ack;
        exp_ack = (idx == 1) ? 2'b10 : 2'b01;
        @(posedge clk);
        #1;
        req[idx] = 1'b1;
        set_fields(idx, rd, mod, wd, addr);
        @(negedge clk);  // T
        check({tag, "_T0_addr"}, 32'(bus_addr), 32'(CSR_IDLE_ADDR));
        check({tag, "_T0_mod"}, 32'(bus_modify), 32'(MOD_NONE));
        @(negedge clk);  // T+1
        check({tag, "_T1_addr"}, 32'(bus_addr), 32'(addr));
        check({tag, "_T1_mod"}, 32'(bus_modify), 32'(mod));
        check({tag, "_T1_read"}, 32'(bus_read), 32'(rd));
        check({tag, "_T1_wdata"}, bus_wdata, wd);
        set_fields(idx, ~rd, MOD_CLEAR, ~wd, ~addr);
        @(negedge clk);  // T+2
        check({tag, "_T2_addr"}, 32'(bus_addr), 32'(CSR_IDLE_ADDR));
        check({tag, "_T2_mod"}, 32'(bus_modify), 32'(MOD_NONE));
        check({tag, "_T2_ack"}, 32'(ack), 32'h0);
        @(negedge clk);  // T+3
        check({tag, "_T3_ack"}, 32'(ack), 32'(exp_ack));
        check({tag, "_T3_rdata"}, rdata, exp_rdata);
        check({tag, "_T3_hit"}, 32'(hit), 32'(exp_hit));
        @(posedge clk);
        #1;
        req[idx] = 1'b0;
        set_fields(idx, 1'b0, MOD_NONE, 32'h0, 12'h000);
        @(negedge clk);  // T+4: the held req in the ack cycle must not have been regranted
        check({tag, "_T4_addr"}, 32'(bus_addr), 32'(CSR_IDLE_ADDR));
        check({tag, "_T4_ack"}, 32'(ack), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] ack_seen [4];
        int         ack_when [4];
        int         n_ack;
        logic [1:0] first_ack;
        int         first_when;
        logic [1:0] exp_first;

        rstn       = 1'b0;
        req        = '0;
        req_read   = '0;
        req_modify = '0;
        req_wdata  = '0;
        req_addr   = '0;

        #1;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_hit", 32'(hit), 32'h0);
        check("rst_addr", 32'(bus_addr), 32'(CSR_IDLE_ADDR));
        check("rst_mod", 32'(bus_modify), 32'(MOD_NONE));
        check("rst_read", 32'(bus_read), 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        do_txn(0, 1'b1, MOD_NONE, 32'h0, 12'hF11, 32'h0000_0005, 1'b1, "rd0");
        do_txn(1, 1'b1, MOD_NONE, 32'h0, 12'h123, 32'h0, 1'b0, "illegal1");

        // Both held continuously: ack masking alternates the grant in either build.
        @(posedge clk);
        #1;
        req = 2'b11;
        set_fields(0, 1'b1, MOD_NONE, 32'h0, 12'hF11);
        set_fields(1, 1'b1, MOD_NONE, 32'h0, 12'h300);
        n_ack = 0;
        for (int c = 0; c < 20 && n_ack < 4; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                ack_seen[n_ack] = ack;
                ack_when[n_ack] = c;
                if (ack == 2'b01) check("both_rdata0", rdata, 32'h0000_0005);
                else              check("both_rdata1", rdata, 32'h0000_00FF);
                n_ack++;
                if (n_ack == 4) req = 2'b00;
            end
        end
        check("both_count", 32'(n_ack), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("both_order%0d", k), 32'(ack_seen[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("both_when%0d", k), 32'(ack_when[k]), 32'(3 * (k + 1)));
        end
        set_fields(0, 1'b0, MOD_NONE, 32'h0, 12'h000);
        set_fields(1, 1'b0, MOD_NONE, 32'h0, 12'h000);
        repeat (3) @(negedge clk);
        check("both_idle_addr", 32'(bus_addr), 32'(CSR_IDLE_ADDR));

        do_txn(0, 1'b0, MOD_WRITE, 32'h0000_000A, 12'hBC1, 32'h0, 1'b1, "wr0");

        // Fresh simultaneous request right after a requester-0 grant.
`ifdef CSR_ARB_ROUND_ROBIN_EN
        exp_first = 2'b10;
`else
        exp_first = 2'b01;
`endif
        @(posedge clk);
        #1;
        req = 2'b11;
        set_fields(0, 1'b1, MOD_NONE, 32'h0, 12'hF11);
        set_fields(1, 1'b1, MOD_NONE, 32'h0, 12'h300);
        first_ack  = 2'b00;
        first_when = -1;
        for (int c = 0; c < 8 && first_when < 0; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                first_ack  = ack;
                first_when = c;
                req        = 2'b00;
            end
        end
        req = 2'b00;
        check("fresh_winner", 32'(first_ack), 32'(exp_first));
        check("fresh_when", 32'(first_when), 32'd3);
        repeat (3) @(negedge clk);

        do_txn(1, 1'b1, MOD_NONE, 32'h0, 12'h300, 32'h0000_00FF, 1'b1, "or1");

        // Async reset while the transaction sits in CAPTURE.
        @(posedge clk);
        #1;
        req[0] = 1'b1;
        set_fields(0, 1'b1, MOD_NONE, 32'h0, 12'hF11);
        @(negedge clk);  // T
        @(negedge clk);  // T+1
        @(negedge clk);  // T+2 (CAPTURE)
        #2;
        rstn = 1'b0;
        #1;
        check("arst_ack", 32'(ack), 32'h0);
        check("arst_rdata", rdata, 32'h0);
        check("arst_hit", 32'(hit), 32'h0);
        check("arst_addr", 32'(bus_addr), 32'(CSR_IDLE_ADDR));
        check("arst_mod", 32'(bus_modify), 32'(MOD_NONE));
        @(negedge clk);  // T+3
        check("arst_T3_ack", 32'(ack), 32'h0);
        req = 2'b00;
        set_fields(0, 1'b0, MOD_NONE, 32'h0, 12'h000);
        rstn = 1'b1;

        do_txn(0, 1'b1, MOD_NONE, 32'h0, 12'hF11, 32'h0000_0005, 1'b1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
